// File: rtl/addsub_result_accum_if.sv
// ----------------------------------------------------------------------------
// addsub_result_accum_if
//   Bundles the two handshake channels of the add/subtract result accumulator.
//   Input channel  : in_valid / in_ready carrying in_select (2b) and in_result (4b)
//   Output channel : out_valid / out_ready carrying out_sum (ACC_W b),
//                    out_count (8b), out_ovf and out_err.
//   master : the side feeding samples and taking burst totals (upstream/consumer)
//   slave  : the accumulator itself
// ----------------------------------------------------------------------------
interface addsub_result_accum_if #(
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_select;
    logic [3:0]       in_result;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_select, in_result, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_select, in_result, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf, out_err
    );
endinterface

// File: rtl/addsub_result_accum.sv
// ----------------------------------------------------------------------------
// addsub_result_accum
//   Downstream stage of the 4-bit add/subtract unit. Folds BURST_LEN arithmetic
//   samples into an ACC_W-bit unsigned total, then presents the total with a
//   sticky wrap flag and a sticky "select 3 seen" flag until it is taken.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-high
//     bus  : slave side of addsub_result_accum_if
//            in_valid/in_ready/in_select/in_result  - sample input channel
//            out_valid/out_ready/out_sum/out_count/
//            out_ovf/out_err                        - burst total channel
//
//   Sample handling (while accumulating):
//     select 0 : acc += result, counts toward the burst, carry sets ovf
//     select 1 : acc -= result, counts toward the burst, borrow sets ovf
//     select 2 : acc and ovf cleared, burst continues, not counted
//     select 3 : sample dropped, err set, not counted
// ----------------------------------------------------------------------------
module addsub_result_accum #(
    parameter int ACC_W     = 8,
    parameter int BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_result_accum_if.slave bus
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] BURST_CNT = 8'(BURST_LEN);

    // Full-width add: bit ACC_W is the carry out of the accumulator.
    function automatic logic [ACC_W:0] wide_add(
        input logic [ACC_W-1:0] a,
        input logic [3:0]       r
    );
        return {1'b0, a} + {{(ACC_W-3){1'b0}}, r};
    endfunction

    // Full-width subtract: bit ACC_W is the borrow (result went negative).
    function automatic logic [ACC_W:0] wide_sub(
        input logic [ACC_W-1:0] a,
        input logic [3:0]       r
    );
        return {1'b0, a} - {{(ACC_W-3){1'b0}}, r};
    endfunction

    state_t           state, state_next;

    logic [ACC_W-1:0] acc_p0, acc_next;
    logic [7:0]       cnt_p0, cnt_next;
    logic             ovf_p0, ovf_next;
    logic             err_p0, err_next;

    logic [ACC_W-1:0] sum_p1, sum_next;
    logic [7:0]       count_p1, count_next;
    logic             ovf_p1, ovf_out_next;
    logic             err_p1, err_out_next;

    logic [ACC_W:0]   wide;
    logic             take;

    always_comb begin
        state_next   = state;
        acc_next     = acc_p0;
        cnt_next     = cnt_p0;
        ovf_next     = ovf_p0;
        err_next     = err_p0;
        sum_next     = sum_p1;
        count_next   = count_p1;
        ovf_out_next = ovf_p1;
        err_out_next = err_p1;
        wide         = '0;
        take         = 1'b0;

        if (state == ACCUM) begin
            if (bus.in_valid) begin
                case (bus.in_select)
                    2'd0: begin
                        wide = wide_add(acc_p0, bus.in_result);
                        take = 1'b1;
                    end
                    2'd1: begin
                        wide = wide_sub(acc_p0, bus.in_result);
                        take = 1'b1;
                    end
                    2'd2: begin
                        acc_next = '0;
                        ovf_next = 1'b0;
                    end
                    default: begin
                        err_next = 1'b1;
                    end
                endcase

                if (take) begin
                    acc_next = wide[ACC_W-1:0];
                    ovf_next = ovf_p0 | wide[ACC_W];
                    cnt_next = cnt_p0 + 8'd1;
                    // The sample that completes the burst is already folded
                    // into the captured total and flags.
                    if (cnt_next == BURST_CNT) begin
                        state_next   = HOLD;
                        sum_next     = acc_next;
                        count_next   = cnt_next;
                        ovf_out_next = ovf_next;
                        err_out_next = err_p0;
                    end
                end
            end
        end else begin
            // The burst state is cleared on the taking edge; the next burst
            // can only start once in_ready rises in the following cycle.
            if (bus.out_ready) begin
                state_next = ACCUM;
                acc_next   = '0;
                cnt_next   = '0;
                ovf_next   = 1'b0;
                err_next   = 1'b0;
            end
        end
    end

    // ---- stage p0: running burst state / stage p1: captured burst total ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            ovf_p0   <= 1'b0;
            err_p0   <= 1'b0;
            sum_p1   <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_next;
            acc_p0   <= acc_next;
            cnt_p0   <= cnt_next;
            ovf_p0   <= ovf_next;
            err_p0   <= err_next;
            sum_p1   <= sum_next;
            count_p1 <= count_next;
            ovf_p1   <= ovf_out_next;
            err_p1   <= err_out_next;
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_p1;
    assign bus.out_count = count_p1;
    assign bus.out_ovf   = ovf_p1;
    assign bus.out_err   = err_p1;

endmodule

// File: tb/tb_addsub_result_accum.sv
// ----------------------------------------------------------------------------
// tb_addsub_result_accum
//   Scoreboard bench: every accepted sample updates a reference model; each
//   completed burst pushes its expected total, which is popped and compared
//   when the DUT presents out_valid.
// ----------------------------------------------------------------------------
module tb_addsub_result_accum;

    localparam int ACC_W = 8;
    localparam int BL    = 8;
    localparam int MOD   = 1 << ACC_W;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [7:0]       cnt;
        logic             ovf;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    addsub_result_accum_if #(.ACC_W(ACC_W)) bus ();

    addsub_result_accum #(.ACC_W(ACC_W), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_ovf = 0;
    bit   m_err = 0;

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_accept(input logic [1:0] s, input logic [3:0] r);
        exp_t e;
        case (s)
            2'd0: begin
                m_acc = m_acc + int'(r);
                if (m_acc >= MOD) begin m_acc = m_acc - MOD; m_ovf = 1; end
                m_cnt++;
            end
            2'd1: begin
                if (int'(r) > m_acc) begin m_acc = m_acc - int'(r) + MOD; m_ovf = 1; end
                else m_acc = m_acc - int'(r);
                m_cnt++;
            end
            2'd2: begin m_acc = 0; m_ovf = 0; end
            default: m_err = 1;
        endcase
        if (m_cnt == BL) begin
            e.sum = m_acc[ACC_W-1:0];
            e.cnt = 8'(m_cnt);
            e.ovf = m_ovf;
            e.err = m_err;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Drives one sample; returns #1 after the edge that consumed it.
    task automatic send(input logic [1:0] s, input logic [3:0] r);
        int guard = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_select = s;
        bus.in_result = r;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept in_ready=%0b required=1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        model_accept(s, r);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = (bus.out_valid === 1'b1);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() > 0);
        if (ok) e = sb.pop_front();
        else begin e.sum = '0; e.cnt = '0; e.ovf = 0; e.err = 0; end
    endtask

    // Takes the presented total on the next edge and returns #1 after it.
    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", bus.out_valid); end
        total++; if (bus.out_sum !== 8'd0) begin bad++; $display("FAIL reset_out_sum got=%0d required=0", bus.out_sum); end
        total++; if (bus.out_count !== 8'd0) begin bad++; $display("FAIL reset_out_count got=%0d required=0", bus.out_count); end
        total++; if ({bus.out_ovf, bus.out_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b required=00", {bus.out_ovf, bus.out_err}); end
    endtask

    task automatic test_basic();
        exp_t e; bit ok;
        for (int i = 1; i <= 8; i++) send(2'd0, 4'(i));
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency out_valid=%0b required=1", bus.out_valid); end
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_sb_empty got=0 required=1"); end
        total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL basic_sum got=%0d required=%0d", bus.out_sum, e.sum); end
        total++; if (bus.out_sum !== 8'd36) begin bad++; $display("FAIL basic_sum36 got=%0d required=36", bus.out_sum); end
        total++; if (bus.out_count !== e.cnt) begin bad++; $display("FAIL basic_count got=%0d required=%0d", bus.out_count, e.cnt); end
        total++; if ({bus.out_ovf, bus.out_err} !== {e.ovf, e.err}) begin bad++; $display("FAIL basic_flags got=%b required=%b", {bus.out_ovf, bus.out_err}, {e.ovf, e.err}); end
        release_out();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_release_valid got=%0b required=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_release_ready got=%0b required=1", bus.in_ready); end
    endtask

    task automatic test_hold();
        exp_t e; bit ok;
        for (int i = 0; i < 8; i++) send(2'd0, 4'd15);
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_sb_empty got=0 required=1"); end
        // Offer a sample during HOLD; it must not be consumed.
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd0;
        bus.in_result = 4'd9;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%0b required=1", c, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%0b required=0", c, bus.in_ready); end
            total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL hold_sum cyc=%0d got=%0d required=%0d", c, bus.out_sum, e.sum); end
        end
        total++; if (bus.out_sum !== 8'd120) begin bad++; $display("FAIL hold_sum120 got=%0d required=120", bus.out_sum); end
        total++; if (bus.out_count !== e.cnt) begin bad++; $display("FAIL hold_count got=%0d required=%0d", bus.out_count, e.cnt); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%0b required=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%0b required=1", bus.in_ready); end
    endtask

    task automatic test_wrap();
        exp_t e; bit ok;
        send(2'd1, 4'd3);
        for (int i = 0; i < 7; i++) send(2'd0, 4'd15);
        bit_wait: begin
            wait_valid(ok);
            total++; if (!ok) begin bad++; $display("FAIL wrap_timeout out_valid=%0b required=1", bus.out_valid); end
        end
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_sb_empty got=0 required=1"); end
        total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL wrap_sum got=%0d required=%0d", bus.out_sum, e.sum); end
        total++; if (bus.out_sum !== 8'd102) begin bad++; $display("FAIL wrap_sum102 got=%0d required=102", bus.out_sum); end
        total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%0b required=1", bus.out_ovf); end
        total++; if (bus.out_err !== e.err) begin bad++; $display("FAIL wrap_err got=%0b required=%0b", bus.out_err, e.err); end
        release_out();
    endtask

    task automatic test_mix();
        exp_t e; bit ok;
        send(2'd0, 4'd5);
        send(2'd2, 4'd0);
        send(2'd0, 4'd4);
        send(2'd3, 4'd7);
        for (int i = 0; i < 6; i++) send(2'd0, 4'd1);
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL mix_timeout out_valid=%0b required=1", bus.out_valid); end
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL mix_sb_empty got=0 required=1"); end
        total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL mix_sum got=%0d required=%0d", bus.out_sum, e.sum); end
        total++; if (bus.out_count !== 8'd8) begin bad++; $display("FAIL mix_count got=%0d required=8", bus.out_count); end
        total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL mix_err got=%0b required=1", bus.out_err); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL mix_ovf got=%0b required=0", bus.out_ovf); end
        release_out();
    endtask

    task automatic test_reset_mid();
        exp_t e; bit ok;
        for (int i = 0; i < 4; i++) send(2'd0, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b required=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b required=1", bus.in_ready); end
        for (int i = 0; i < 8; i++) send(2'd0, 4'd2);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_latency got=%0b required=1", bus.out_valid); end
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_sb_empty got=0 required=1"); end
        total++; if (bus.out_sum !== 8'd16) begin bad++; $display("FAIL rstmid_sum16 got=%0d required=16", bus.out_sum); end
        total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL rstmid_sum got=%0d required=%0d", bus.out_sum, e.sum); end
        release_out();
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ok;
        int   outs = 0;
        int   cyc  = 0;
        bit   tog  = 0;
        logic [1:0] s;
        logic [3:0] r;
        bus.out_ready = 1'b1;
        while (outs < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            total++; if (bus.in_ready !== ~bus.out_valid) begin bad++; $display("FAIL b2b_ready_vs_valid cyc=%0d in_ready=%0b out_valid=%0b", cyc, bus.in_ready, bus.out_valid); end
            if (bus.out_valid === 1'b1) begin
                pop_exp(e, ok);
                total++; if (!ok) begin bad++; $display("FAIL b2b_sb_empty got=0 required=1"); end
                total++; if (bus.out_sum !== e.sum) begin bad++; $display("FAIL b2b_sum n=%0d got=%0d required=%0d", outs, bus.out_sum, e.sum); end
                total++; if (bus.out_count !== e.cnt) begin bad++; $display("FAIL b2b_count n=%0d got=%0d required=%0d", outs, bus.out_count, e.cnt); end
                total++; if (bus.out_ovf !== e.ovf) begin bad++; $display("FAIL b2b_ovf n=%0d got=%0b required=%0b", outs, bus.out_ovf, e.ovf); end
                outs++;
            end
            tog = ~tog;
            s = 2'($urandom_range(0, 1));
            r = 4'($urandom_range(0, 15));
            bus.in_valid  = tog;
            bus.in_select = s;
            bus.in_result = r;
            if (tog && bus.in_ready === 1'b1) model_accept(s, r);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (outs != 3) begin bad++; $display("FAIL b2b_outputs got=%0d required=3", outs); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d required=0", sb.size()); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_select = 2'd0;
        bus.in_result = 4'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_wrap();
        test_mix();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
